// File: rtl/pokey_serin_rx_if.sv
// pokey_serin_rx_if: signal bundle between the serial-input receiver and its
// surroundings (bit timer, CPU register interface, IRQ/SKSTAT logic).
// Optional macro SERIN_LOOPBACK_EN adds the sod_loop/loop_sel loopback pins.
interface pokey_serin_rx_if;
  logic       enp;
  logic       sid;
  logic       bit_tick;
  logic       serin_rd;
  logic       skres;
`ifdef SERIN_LOOPBACK_EN
  logic       sod_loop;
  logic       loop_sel;
`endif
  logic [7:0] serin;
  logic       rx_done;
  logic       rx_full;
  logic       frame_err;
  logic       overrun;
  logic       timer_resync;
  logic       busy;

  // Receiver side.
  modport slave (
`ifdef SERIN_LOOPBACK_EN
    input  sod_loop, loop_sel,
`endif
    input  enp, sid, bit_tick, serin_rd, skres,
    output serin, rx_done, rx_full, frame_err, overrun, timer_resync, busy
  );

  // Driver side (bit timer / CPU / IRQ block).
  modport master (
`ifdef SERIN_LOOPBACK_EN
    output sod_loop, loop_sel,
`endif
    output enp, sid, bit_tick, serin_rd, skres,
    input  serin, rx_done, rx_full, frame_err, overrun, timer_resync, busy
  );
endinterface

// File: rtl/pokey_serin_rx.sv
// pokey_serin_rx: POKEY serial-input deserializer. Samples the synchronized
// SID line on mid-bit ticks, assembles 1-start / DATA_BITS-data / 1-stop
// frames LSB first, loads SERIN and reports done / frame error / overrun.
// Optional macro SERIN_LOOPBACK_EN: loop_sel=1 feeds sod_loop into the
// synchronizer instead of sid.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line idle, waiting for a low level (start edge)
// START  | start edge seen, waiting for the mid-start-bit tick
// DATA   | shifting data bits, one per tick
// STOP   | waiting for the stop-bit tick to load SERIN
module pokey_serin_rx #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  pokey_serin_rx_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_src;
  logic                   sid_s;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [7:0]             serin_q, serin_d;
  logic                   rx_full_q, rx_full_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   tick;
  logic                   load;
  logic                   resync;
  logic                   ferr_set;
  logic                   ovr_set;

`ifdef SERIN_LOOPBACK_EN
  // The mux sits ahead of the synchronizer, so a loop_sel switch is absorbed there.
  assign sync_src = bus.loop_sel ? bus.sod_loop : bus.sid;
`else
  assign sync_src = bus.sid;
`endif

  assign sid_s = sync_q[SYNC_STAGES-1];
  assign tick  = bus.enp & bus.bit_tick;

  // Input synchronizer, runs every clk; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sync_src};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; nothing moves unless enp is high.
  always_comb begin
    state_d = state_q;
    if (bus.enp) begin
      case (state_q)
        S_IDLE: begin
          if (!sid_s) state_d = S_START;
        end
        S_START: begin
          if (tick) state_d = sid_s ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (tick && (cnt_q == LAST_BIT)) state_d = S_STOP;
        end
        S_STOP: begin
          if (tick) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: strobes and datapath next values.
  always_comb begin
    resync   = 1'b0;
    load     = 1'b0;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        resync = bus.enp & ~sid_s;
      end
      S_START: begin
        if (tick && !sid_s) begin
          cnt_d   = 3'd0;
          shift_d = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {sid_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + 3'd1;
        end
      end
      S_STOP: begin
        load = tick;
      end
      default: ;
    endcase
  end

  // A read in the same clk as a load is treated as coming first: no overrun.
  // Set has priority over skres for both sticky flags.
  always_comb begin
    ferr_set    = load & ~sid_s;
    ovr_set     = load & rx_full_q & ~bus.serin_rd;
    serin_d     = load ? 8'(shift_q) : serin_q;
    rx_full_d   = load | (rx_full_q & ~bus.serin_rd);
    frame_err_d = ferr_set | (frame_err_q & ~bus.skres);
    overrun_d   = ovr_set | (overrun_q & ~bus.skres);
  end

  // Shift register and data bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= 3'd0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // SERIN holding register and status flags (serin_rd/skres act on any clk).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      serin_q     <= 8'h00;
      rx_full_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      serin_q     <= serin_d;
      rx_full_q   <= rx_full_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.serin        = serin_q;
  assign bus.rx_done      = load;
  assign bus.rx_full      = rx_full_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.overrun      = overrun_q;
  assign bus.timer_resync = resync;
  assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: doc/pokey_serin_rx.md
Name: pokey_serin_rx

Overview:
Serial-input deserializer for the POKEY serial port; the receive counterpart of the transmit shift chain. It samples the SID line on externally generated mid-bit ticks, assembles async frames (1 start, DATA_BITS data LSB-first, 1 stop) and loads the SERIN holding register. It raises receive-done, frame-error and overrun status for the IRQ/SKSTAT logic. It also emits a resync pulse so the channel 3/4 bit timer restarts on each detected start edge.

Parameters:
DATA_BITS, 8, data bits per frame (legal 5..8); SERIN is always 8 bits, and unused MSBs read 0 (right-justified)
SYNC_STAGES, 2, flip-flop stages on SID before use (legal 2..3)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enp  input  1  slow-clock enable; all state except the synchronizer advances only when enp=1
sid  input  1  raw serial data in, idle high
bit_tick  input  1  mid-bit sample strobe from bit timer; honoured only when enp=1
serin_rd  input  1  one-clk pulse, CPU read of SERIN; clears rx_full
skres  input  1  one-clk pulse, SKRES write; clears frame_err and overrun
serin  output  8  last received byte
rx_done  output  1  one-enp-cycle pulse when SERIN loads (serial-input-done IRQ source)
rx_full  output  1  SERIN holds an unread byte
frame_err  output  1  sticky: stop bit sampled low
overrun  output  1  sticky: byte loaded while rx_full=1
timer_resync  output  1  one-enp-cycle pulse on start-edge detection
busy  output  1  1 in any state other than IDLE

Behaviour:
- Reset (async, any time, including mid-frame): state=IDLE, shift reg=0, bit count=0, serin=8'h00, synchronizer stages=1, and all flags and pulses=0.
- Synchronizer: SID passes through SYNC_STAGES flops clocked every clk, ungated by enp; sid_s is the last stage.
- FSM (advances only on enp=1):
  - IDLE: if sid_s=0, go to START and pulse timer_resync for that enp cycle.
  - START: on bit_tick, if sid_s=0 go to DATA with count=0. If sid_s=1, it is a false start: go to IDLE with no flags.
  - DATA: on bit_tick, shift right with sid_s entering the MSB of the DATA_BITS shift reg, and increment count. After the DATA_BITS-th tick, go to STOP.
  - STOP: on bit_tick, load serin with the shift reg (right-justified, LSB = first data bit) and pulse rx_done. If sid_s=0, set frame_err; the byte is still loaded. If rx_full=1 at load, set overrun; serin is still overwritten. Set rx_full, then go to IDLE.
- A new start is accepted the enp cycle after STOP exit. Back-to-back frames need no extra idle bit.
- Ticks arriving in IDLE are ignored.
- Simultaneous events:
  - serin_rd and load in the same clk: rx_full=1 and overrun is evaluated as if the read came first, so no overrun.
  - skres and an error in the same clk: the flag is set (set wins).
  - skres does not affect rx_full, serin, or the FSM.
- serin_rd and skres act on any clk, independent of enp.
- Latency: rx_done asserts in the enp cycle of the stop-bit tick.

Optional Feature:
SERIN_LOOPBACK_EN: adds input ports sod_loop (1) and loop_sel (1). When loop_sel=1, the synchronizer input is sod_loop instead of sid; the switch is glitch-free because the synchronizer absorbs it. Without the macro, these ports do not exist and sid is used unconditionally. FSM behaviour is identical either way.

Test Plan:
- Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) with enp=1 and a tick every 16 clk -> serin=8'hA5, one rx_done pulse, rx_full=1, frame_err=0, overrun=0, one timer_resync pulse.
- Two frames 0x3C then 0xC3 with no serin_rd between -> serin=8'hC3, overrun=1. Then pulse skres -> overrun=0 while rx_full stays 1; serin_rd -> rx_full=0.
- Frame 0x55 with stop bit 0 -> serin=8'h55, frame_err=1 until skres. The next frame starting immediately after is received correctly.
- sid low for 4 clk then high before the first tick -> FSM returns to IDLE, no rx_done, serin unchanged, one timer_resync pulse only.
- Assert reset at the 4th data bit of a frame -> all outputs 0 and busy=0 immediately. A following full frame 0x81 is received as 8'h81.
- DATA_BITS=7 with frame data 0x7F -> serin=8'h7F, serin[7]=0. With SERIN_LOOPBACK_EN, loop_sel=1, sod_loop driving 0x12 and sid held high -> serin=8'h12.
